// File: rtl/cmp_seq_ctrl.sv
// cmp_seq_ctrl
// Sequences a WIDTH-bit unsigned magnitude compare through one external,
// combinational 4-bit cascadable comparator. Operands are walked one nibble
// per cycle, least-significant nibble first. Each nibble result is registered
// and fed back as the cascade input for the next, more significant nibble.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   start                     request pulse, sampled only in IDLE
//   a, b                      operands, latched when start is accepted
//   busy                      high in RUN and DONE
//   done                      one-cycle pulse, result valid
//   a_lt, a_eq, a_gt          registered result, held until the next done
//   cmp_err                   comparator gave a non-one-hot result this operation
//   cmp_a, cmp_b              nibble driven to the comparator
//   cmp_li, cmp_ei, cmp_gi    cascade inputs (lower-nibble result)
//   cmp_lo, cmp_eo, cmp_go    comparator outputs for the current nibble
module cmp_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_lt,
  output logic             a_eq,
  output logic             a_gt,
  output logic             cmp_err,
  output logic [3:0]       cmp_a,
  output logic [3:0]       cmp_b,
  output logic             cmp_li,
  output logic             cmp_ei,
  output logic             cmp_gi,
  input  logic             cmp_lo,
  input  logic             cmp_eo,
  input  logic             cmp_go
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] sa, sb;
  logic [IDXW-1:0]  idx;
  logic             cl, ce, cg;
  logic             err_sticky;
  logic [2:0]       captured;
  logic             one_hot;
  logic             last_nib;

  assign captured = {cmp_lo, cmp_eo, cmp_go};
  assign one_hot  = (captured == 3'b100) || (captured == 3'b010) || (captured == 3'b001);
  assign last_nib = (idx == LAST_IDX);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and comparator-facing outputs. Outside RUN the comparator sees
  // zero nibbles and an "equal" cascade so it idles in a defined state.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    cmp_a      = 4'd0;
    cmp_b      = 4'd0;
    cmp_li     = 1'b0;
    cmp_ei     = 1'b1;
    cmp_gi     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy   = 1'b1;
        cmp_a  = sa[3:0];
        cmp_b  = sb[3:0];
        cmp_li = cl;
        cmp_ei = ce;
        cmp_gi = cg;
        if (last_nib) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand shift registers, cascade feedback and result capture.
  // A non-one-hot comparator result is passed through untouched; only the
  // sticky error flag records that it happened.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa         <= '0;
      sb         <= '0;
      idx        <= '0;
      cl         <= 1'b0;
      ce         <= 1'b0;
      cg         <= 1'b0;
      err_sticky <= 1'b0;
      a_lt       <= 1'b0;
      a_eq       <= 1'b0;
      a_gt       <= 1'b0;
      cmp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa         <= a;
            sb         <= b;
            idx        <= '0;
            cl         <= 1'b0;
            ce         <= 1'b1;
            cg         <= 1'b0;
            err_sticky <= 1'b0;
          end
        end
        RUN: begin
          {cl, ce, cg} <= captured;
          sa           <= sa >> 4;
          sb           <= sb >> 4;
          idx          <= idx + IDXW'(1);
          if (!one_hot) err_sticky <= 1'b1;
          if (last_nib) begin
            {a_lt, a_eq, a_gt} <= captured;
            cmp_err            <= err_sticky | ~one_hot;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
